// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register scoreboard beside the decode stage.
// Tracks the youngest in-flight writer of each architectural register
// (valid, current stage, result latency). It derives the decode stall, the
// per-source forwarding selects, the flush-time cancel and a saturating
// stall-cycle counter.
module hazard_scoreboard #(
    parameter int NUM_REGS  = 4,
    parameter int NUM_SRC   = 2,
    parameter int DEPTH     = 3,
    parameter int FLUSH_AGE = 1,
    parameter int CNT_W     = 16,
    localparam int AW       = $clog2(NUM_REGS),
    localparam int SW       = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_valid,
    input  logic                   issue_wen,
    input  logic [AW-1:0]          issue_rd,
    input  logic [SW-1:0]          issue_lat,
    input  logic [NUM_SRC*AW-1:0]  issue_rs,
    input  logic [NUM_SRC-1:0]     issue_rs_en,
    input  logic                   flush,
    output logic                   stall,
    output logic [NUM_SRC*SW-1:0]  fwd_sel,
    output logic [NUM_REGS-1:0]    busy,
    output logic [CNT_W-1:0]       stall_cnt
);

    // Latency 0 means "ready after EX"; latencies at or beyond the last
    // stage are pulled back so the value can still be forwarded.
    function automatic logic [SW-1:0] clamp_lat(input logic [SW-1:0] lat);
        if (lat == '0) begin
            return SW'(1);
        end
        if (32'(lat) >= DEPTH) begin
            return SW'(DEPTH - 1);
        end
        return lat;
    endfunction

    // Counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    // Scoreboard entries: valid is control state (reset), age/lat are data.
    logic [NUM_REGS-1:0] r_valid;
    logic [SW-1:0]       r_age [NUM_REGS];
    logic [SW-1:0]       r_lat [NUM_REGS];
    logic [CNT_W-1:0]    r_stall_cnt;

    logic                w_wait;
    logic                w_stall;
    logic                w_accept;
    logic [NUM_SRC*SW-1:0] w_fwd;
    logic [AW-1:0]       w_src;
    logic [SW-1:0]       w_lat_clamped;
    logic [NUM_REGS-1:0] w_wr;
    logic [NUM_REGS-1:0] w_cancel;
    logic [NUM_REGS-1:0] w_retire;

    // Source check against pre-edge entries: ready producers give a forward
    // stage, unready ones request a stall. Held quiet while in reset so the
    // outputs never reflect stale entries.
    always_comb begin
        w_wait = 1'b0;
        w_fwd  = '0;
        w_src  = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            w_src = issue_rs[s*AW +: AW];
            if (issue_rs_en[s] && r_valid[w_src]) begin
                if (r_age[w_src] >= r_lat[w_src]) begin
                    if (32'(r_age[w_src]) + 1 <= DEPTH) begin
                        w_fwd[s*SW +: SW] = r_age[w_src] + SW'(1);
                    end
                end else begin
                    w_wait = 1'b1;
                end
            end
        end
        if (rst) begin
            w_wait = 1'b0;
            w_fwd  = '0;
        end
    end

    assign w_stall       = issue_valid & ~flush & ~rst & w_wait;
    assign w_accept      = issue_valid & ~w_stall & ~flush;
    assign w_lat_clamped = clamp_lat(issue_lat);

    // Per-entry events: overwrite by an accepted writer, flush cancel of young
    // entries, and retirement once the writer sits in the last stage.
    always_comb begin
        w_wr     = '0;
        w_cancel = '0;
        w_retire = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            w_wr[r]     = w_accept & issue_wen & (issue_rd == AW'(r));
            w_cancel[r] = flush & (32'(r_age[r]) <= FLUSH_AGE);
            w_retire[r] = (32'(r_age[r]) == DEPTH);
        end
    end

    // Valid bits: a new writer wins over cancel/retire of the old one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (w_wr[r]) begin
                    r_valid[r] <= 1'b1;
                end else if (r_valid[r] && (w_cancel[r] || w_retire[r])) begin
                    r_valid[r] <= 1'b0;
                end
            end
        end
    end

    // Age/latency fields: restart at EX on overwrite, otherwise advance one
    // stage per cycle until the writer reaches the register file.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (w_wr[r]) begin
                r_age[r] <= SW'(1);
                r_lat[r] <= w_lat_clamped;
            end else if (r_valid[r] && !w_retire[r]) begin
                r_age[r] <= r_age[r] + SW'(1);
            end
        end
    end

    // Saturating count of cycles spent stalling decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall) begin
            r_stall_cnt <= sat_inc(r_stall_cnt);
        end
    end

    assign stall     = w_stall;
    assign fwd_sel   = w_fwd;
    assign busy      = r_valid;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard: three instances (default, 2-bit counter,
// 8-reg/3-src/depth-5). Stimulus pushes expected values into a queue; a
// monitor pops and compares them at the falling edge.
module tb_hazard_scoreboard;

  logic clk;
  logic rst;
  logic rst1;

  // Instance 0: defaults
  logic       iv0, iw0, ifl0;
  logic [1:0] ird0, ilat0, ien0;
  logic [3:0] irs0;
  logic       st0;
  logic [3:0] fw0, bz0;
  logic [15:0] cn0;

  // Instance 1: CNT_W = 2
  logic       iv1, iw1, ifl1;
  logic [1:0] ird1, ilat1, ien1;
  logic [3:0] irs1;
  logic       st1;
  logic [3:0] fw1, bz1;
  logic [1:0] cn1;

  // Instance 2: NUM_REGS=8, NUM_SRC=3, DEPTH=5
  logic       iv2, iw2, ifl2;
  logic [2:0] ird2, ilat2, ien2;
  logic [8:0] irs2;
  logic       st2;
  logic [8:0] fw2;
  logic [7:0] bz2;
  logic [15:0] cn2;

  hazard_scoreboard u0 (
    .clk(clk), .rst(rst), .issue_valid(iv0), .issue_wen(iw0),
    .issue_rd(ird0), .issue_lat(ilat0), .issue_rs(irs0),
    .issue_rs_en(ien0), .flush(ifl0), .stall(st0), .fwd_sel(fw0),
    .busy(bz0), .stall_cnt(cn0)
  );

  hazard_scoreboard #(.CNT_W(2)) u1 (
    .clk(clk), .rst(rst1), .issue_valid(iv1), .issue_wen(iw1),
    .issue_rd(ird1), .issue_lat(ilat1), .issue_rs(irs1),
    .issue_rs_en(ien1), .flush(ifl1), .stall(st1), .fwd_sel(fw1),
    .busy(bz1), .stall_cnt(cn1)
  );

  hazard_scoreboard #(.NUM_REGS(8), .NUM_SRC(3), .DEPTH(5)) u2 (
    .clk(clk), .rst(rst), .issue_valid(iv2), .issue_wen(iw2),
    .issue_rd(ird2), .issue_lat(ilat2), .issue_rs(irs2),
    .issue_rs_en(ien2), .flush(ifl2), .stall(st2), .fwd_sel(fw2),
    .busy(bz2), .stall_cnt(cn2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 = stall, 1 = fwd_sel, 2 = busy, 3 = stall_cnt
  typedef struct {
    int          inst;
    int          kind;
    string       name;
    logic [31:0] exp;
  } rec_t;

  rec_t q[$];
  int   n_total  = 0;
  int   n_passed = 0;

  function automatic logic [31:0] actual(input int inst, input int kind);
    logic [31:0] a;
    a = '0;
    case (inst)
      0: case (kind)
           0: a = 32'(st0);
           1: a = 32'(fw0);
           2: a = 32'(bz0);
           default: a = 32'(cn0);
         endcase
      1: case (kind)
           0: a = 32'(st1);
           1: a = 32'(fw1);
           2: a = 32'(bz1);
           default: a = 32'(cn1);
         endcase
      default: case (kind)
           0: a = 32'(st2);
           1: a = 32'(fw2);
           2: a = 32'(bz2);
           default: a = 32'(cn2);
         endcase
    endcase
    return a;
  endfunction

  // Monitor: compare every expectation queued for this cycle.
  always @(negedge clk) begin
    rec_t        r;
    logic [31:0] a;
    while (q.size() > 0) begin
      r = q.pop_front();
      a = actual(r.inst, r.kind);
      n_total++;
      if (a === r.exp) begin
        n_passed++;
      end else begin
        $display("FAIL %s (inst%0d): got %0d, expected %0d",
                 r.name, r.inst, a, r.exp);
      end
    end
  end

  task automatic ex(input int inst, input int kind, input string nm,
                    input logic [31:0] v);
    rec_t r;
    r.inst = inst;
    r.kind = kind;
    r.name = nm;
    r.exp  = v;
    q.push_back(r);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic d0(input logic v, input logic w, input logic [1:0] rd,
                    input logic [1:0] lat, input logic [3:0] rs,
                    input logic [1:0] en, input logic fl);
    iv0 = v; iw0 = w; ird0 = rd; ilat0 = lat; irs0 = rs; ien0 = en; ifl0 = fl;
  endtask

  task automatic d1(input logic v, input logic w, input logic [1:0] rd,
                    input logic [1:0] lat, input logic [3:0] rs,
                    input logic [1:0] en, input logic fl);
    iv1 = v; iw1 = w; ird1 = rd; ilat1 = lat; irs1 = rs; ien1 = en; ifl1 = fl;
  endtask

  task automatic d2(input logic v, input logic w, input logic [2:0] rd,
                    input logic [2:0] lat, input logic [8:0] rs,
                    input logic [2:0] en, input logic fl);
    iv2 = v; iw2 = w; ird2 = rd; ilat2 = lat; irs2 = rs; ien2 = en; ifl2 = fl;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int sat_cnt [10];
    sat_cnt = '{0, 1, 1, 2, 2, 3, 3, 3, 3, 3};

    rst  = 1'b1;
    rst1 = 1'b1;
    d0(0, 0, 0, 0, 0, 0, 0);
    d1(0, 0, 0, 0, 0, 0, 0);
    d2(0, 0, 0, 0, 0, 0, 0);
    ex(0, 0, "rst_stall", 0);
    ex(0, 1, "rst_fwd", 0);
    step();
    step();
    rst  = 1'b0;
    rst1 = 1'b0;
    ex(0, 2, "rst_busy", 0);
    ex(0, 3, "rst_cnt", 0);
    ex(1, 2, "rst_busy", 0);
    ex(1, 3, "rst_cnt", 0);
    ex(2, 2, "rst_busy", 0);
    ex(2, 3, "rst_cnt", 0);

    // ALU forwarding chain
    step(); d0(1, 1, 1, 1, 4'b0000, 2'b00, 0);
    ex(0, 0, "alu_prod_stall", 0);
    for (int i = 0; i < 3; i++) begin
      step(); d0(1, 1, 1, 1, 4'b0001, 2'b01, 0);
      ex(0, 0, "alu_cons_stall", 0);
      ex(0, 1, "alu_cons_fwd", 2);
    end
    step(); d0(1, 0, 0, 1, 4'b0000, 2'b00, 0);
    ex(0, 2, "alu_busy", 4'b0010);
    step(); d0(1, 0, 0, 1, 4'b0001, 2'b01, 0);
    ex(0, 1, "alu_wb_fwd", 3);
    step();
    ex(0, 1, "alu_rf_fwd", 0);
    ex(0, 2, "alu_busy_last", 4'b0010);
    step(); d0(0, 0, 0, 0, 0, 0, 0);
    ex(0, 2, "alu_retire", 0);

    // Load-use
    step(); d0(1, 1, 1, 2, 4'b0000, 2'b00, 0);
    step(); d0(1, 0, 0, 1, 4'b0101, 2'b11, 0);
    ex(0, 0, "lu_stall", 1);
    ex(0, 1, "lu_stall_fwd", 0);
    ex(0, 3, "lu_cnt0", 0);
    step();
    ex(0, 0, "lu_go_stall", 0);
    ex(0, 1, "lu_go_fwd", 4'b1111);
    ex(0, 3, "lu_cnt1", 1);
    step(); d0(0, 0, 0, 0, 0, 0, 0);
    ex(0, 3, "lu_cnt_hold", 1);
    step();
    ex(0, 2, "lu_retire", 0);

    // Flush
    step(); d0(1, 1, 3, 1, 4'b0000, 2'b00, 0);
    step(); d0(1, 1, 2, 1, 4'b0000, 2'b00, 0);
    step(); d0(1, 1, 0, 1, 4'b0010, 2'b01, 1);
    ex(0, 0, "fl_stall", 0);
    ex(0, 2, "fl_busy_pre", 4'b1100);
    step(); d0(0, 0, 0, 0, 0, 0, 0);
    ex(0, 2, "fl_busy_post", 4'b1000);
    step();
    ex(0, 2, "fl_r3_retire", 0);
    step(); d0(1, 1, 1, 2, 4'b0000, 2'b00, 0);
    step(); d0(1, 0, 0, 1, 4'b0001, 2'b01, 1);
    ex(0, 0, "fl_forced_stall", 0);
    step(); d0(1, 0, 0, 1, 4'b0001, 2'b01, 0);
    ex(0, 0, "fl_cancel_stall", 0);
    ex(0, 1, "fl_cancel_fwd", 0);
    ex(0, 2, "fl_cancel_busy", 0);
    ex(0, 3, "fl_cnt", 1);

    // Write-after-write
    step(); d0(1, 1, 2, 2, 4'b0000, 2'b00, 0);
    step(); d0(1, 1, 2, 1, 4'b0000, 2'b00, 0);
    ex(0, 0, "waw_second_stall", 0);
    step(); d0(1, 0, 0, 1, 4'b0010, 2'b01, 0);
    ex(0, 0, "waw_stall", 0);
    ex(0, 1, "waw_fwd", 2);
    step(); d0(0, 0, 0, 0, 0, 0, 0);
    step();
    ex(0, 2, "waw_busy_hold", 4'b0100);
    step();
    ex(0, 2, "waw_busy_clear", 0);

    // Latency clamp: 3 on a depth-3 pipe behaves as 2
    step(); d0(1, 1, 3, 3, 4'b0000, 2'b00, 0);
    step(); d0(1, 0, 0, 1, 4'b1100, 2'b10, 0);
    ex(0, 0, "clamp_stall", 1);
    ex(0, 1, "clamp_stall_fwd", 0);
    step();
    ex(0, 0, "clamp_go_stall", 0);
    ex(0, 1, "clamp_fwd", 4'b1100);
    ex(0, 3, "clamp_cnt", 2);
    step(); d0(0, 0, 0, 0, 0, 0, 0);

    // Saturation with a 2-bit counter, then reset mid-stall
    step(); d1(1, 1, 1, 2, 4'b0000, 2'b00, 0);
    ex(1, 3, "sat_cnt_start", 0);
    for (int k = 2; k <= 11; k++) begin
      step(); d1(1, 1, 1, 2, 4'b0001, 2'b01, 0);
      ex(1, 0, "sat_stall", (k % 2 == 0) ? 32'd1 : 32'd0);
      ex(1, 3, "sat_cnt", 32'(sat_cnt[k-2]));
    end
    step(); rst1 = 1'b1;
    ex(1, 0, "sat_rst_stall", 0);
    ex(1, 3, "sat_cnt_pre_rst", 3);
    ex(1, 2, "sat_busy_pre_rst", 4'b0010);
    step(); rst1 = 1'b0;
    ex(1, 2, "sat_rst_busy", 0);
    ex(1, 3, "sat_rst_cnt", 0);
    ex(1, 0, "sat_rst_nohazard", 0);
    ex(1, 1, "sat_rst_fwd", 0);
    step(); d1(0, 0, 0, 0, 0, 0, 0);

    // Parametrised config: lat=4 on a depth-5 pipe
    step(); d2(1, 1, 7, 4, 9'd0, 3'b000, 0);
    for (int k = 0; k < 3; k++) begin
      step(); d2(1, 0, 0, 1, {3'd7, 3'd0, 3'd0}, 3'b100, 0);
      ex(2, 0, "cfg_stall", 1);
      ex(2, 1, "cfg_stall_fwd", 0);
      if (k == 0) ex(2, 2, "cfg_busy", 8'h80);
    end
    step();
    ex(2, 0, "cfg_go_stall", 0);
    ex(2, 1, "cfg_fwd", 9'd320);
    ex(2, 3, "cfg_cnt", 3);
    step(); d2(0, 0, 0, 0, 9'd0, 3'b000, 0);

    @(negedge clk);
    #1;

    n_total++;
    if (st0 === 1'b0 && fw0 === 4'd0) begin
      n_passed++;
    end else begin
      $display("FAIL end_idle (inst0): got stall=%0d fwd=%0d, expected 0/0", st0, fw0);
    end
    n_total++;
    if (st1 === 1'b0 && fw1 === 4'd0) begin
      n_passed++;
    end else begin
      $display("FAIL end_idle (inst1): got stall=%0d fwd=%0d, expected 0/0", st1, fw1);
    end
    n_total++;
    if (st2 === 1'b0 && fw2 === 9'd0) begin
      n_passed++;
    end else begin
      $display("FAIL end_idle (inst2): got stall=%0d fwd=%0d, expected 0/0", st2, fw2);
    end

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
